// File: rtl/serial_deser_rx.sv
// serial_deser_rx: framed serial-to-parallel receiver.
//   Frame: start(0), WIDTH data bits, [even parity], stop(1), sampled on sin_en strobes.
//   Word order follows msb_first, captured at the start bit.
//   Optional feature macro: PARITY_EN (adds a parity bit and live parity_err).
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   sin        serial data line (idles high)
//   sin_en     bit strobe; sin is only sampled when high
//   msb_first  1: first data bit is MSB, 0: first data bit is LSB
//   dout       received word (valid/ready output port)
//   dout_valid dout holds an unconsumed word
//   dout_ready consumer accepts dout on an edge with dout_valid=1
//   frame_err  one-cycle pulse, stop bit sampled as 0
//   parity_err one-cycle pulse, parity mismatch (0 without PARITY_EN)
//   overrun    sticky, a good word was dropped because dout was full
module serial_deser_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             msb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_e;
`endif

  state_e          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            ovr_q, ovr_d;
  logic            parity_bad;

`ifdef PARITY_EN
  logic            par_q, par_d;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign parity_bad = ^{sr_q, par_q};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`else
  assign parity_bad = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dout_d  = dout_q;
    // A pending word is consumed on any edge where the consumer is ready.
    valid_d = valid_q & ~dout_ready;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    ovr_d   = ovr_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (sin_en && !sin) begin
          dir_d   = msb_first;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (sin_en) begin
          if (dir_q) sr_d = {sr_q[WIDTH-2:0], sin};
          else       sr_d = {sin, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (sin_en) begin
          par_d   = sin;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sin_en) begin
          state_d = IDLE;
          if (!sin) begin
            ferr_d = 1'b1;
          end else if (parity_bad) begin
            perr_d = 1'b1;
          end else if (!valid_q || dout_ready) begin
            // Holding register is free or being emptied on this same edge.
            dout_d  = sr_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deser_rx.sv
// tb_serial_deser_rx: scoreboard bench for serial_deser_rx (WIDTH=4).
// Stimulus pushes expected words and error pulses; a negedge monitor pops and compares.
module tb_serial_deser_rx;
  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             sin;
  logic             sin_en;
  logic             msb_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  int exp_ferr = 0;
  int exp_perr = 0;

  serial_deser_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .sin        (sin),
    .sin_en     (sin_en),
    .msb_first  (msb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every consumed word and every error pulse.
  always @(negedge clk) begin
    if (!clr) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word: unexpected word %0h, none expected", dout);
        end else begin
          check("word", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) begin
        total++;
        if (exp_ferr == 0) begin
          bad++;
          $display("FAIL frame_err: got unexpected pulse, expected none");
        end else exp_ferr--;
      end
      if (parity_err) begin
        total++;
        if (exp_perr == 0) begin
          bad++;
          $display("FAIL parity_err: got unexpected pulse, expected none");
        end else exp_perr--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobed bit, then optional idle cycles with the line inverted.
  task automatic strobe(input logic b, input int gap);
    sin    = b;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      sin = ~b;
      tick();
    end
    sin = 1'b1;
  endtask

  // bits[3] is sent first; par_good selects a correct or inverted parity bit.
  task automatic send_frame(input logic [WIDTH-1:0] bits, input logic msb, input logic stop,
                            input logic par_good, input int gap, input logic flip);
    msb_first = msb;
    strobe(1'b0, gap);
    if (flip) msb_first = ~msb;
    for (int i = WIDTH - 1; i >= 0; i--) strobe(bits[i], gap);
`ifdef PARITY_EN
    strobe((^bits) ^ ~par_good, gap);
`endif
    strobe(stop, gap);
  endtask

  task automatic idle(input int n);
    sin_en = 1'b0;
    sin    = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clr        = 1'b1;
    sin        = 1'b1;
    sin_en     = 1'b0;
    msb_first  = 1'b1;
    dout_ready = 1'b1;
    idle(3);
    clr = 1'b0;
    tick();
    check("reset dout", 32'(dout), 32'h0);
    check("reset valid", 32'(dout_valid), 32'h0);
    check("reset ferr", 32'(frame_err), 32'h0);
    check("reset perr", 32'(parity_err), 32'h0);
    check("reset ovr", 32'(overrun), 32'h0);

    // Abort a frame with clr after two data bits, then a clean frame.
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    clr = 1'b1;
    tick();
    check("abort valid", 32'(dout_valid), 32'h0);
    clr = 1'b0;
    tick();
    exp_q.push_back(4'b0101);
    send_frame(4'b0101, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("after abort valid", 32'(dout_valid), 32'h1);
    check("after abort dout", 32'(dout), 32'h5);
    idle(2);
    check("valid one cycle", 32'(dout_valid), 32'h0);

    // MSB-first and LSB-first of the same bit sequence.
    exp_q.push_back(4'b1010);
    send_frame(4'b1010, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle(2);
    exp_q.push_back(4'b0101);
    send_frame(4'b1010, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    idle(2);

    // msb_first toggled after the start bit must not affect this frame.
    exp_q.push_back(4'b1010);
    send_frame(4'b1010, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    idle(2);

    // Sparse strobes: idle cycles between bits leave state unchanged.
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    idle(2);

    // Bad stop bit.
    exp_ferr++;
    send_frame(4'b1100, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("bad stop valid", 32'(dout_valid), 32'h0);
    idle(2);

    // Back-to-back frames with sin_en continuously high.
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0111);
    send_frame(4'b1001, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'b0111, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle(2);

    // Consume and load on the same edge: no overrun.
    dout_ready = 1'b0;
    exp_q.push_back(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    exp_q.push_back(4'b0011);
    msb_first = 1'b1;
    strobe(1'b0, 0);
    strobe(1'b0, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
`ifdef PARITY_EN
    strobe(1'b0, 0);
`endif
    dout_ready = 1'b1;
    strobe(1'b1, 0);
    check("same-edge valid", 32'(dout_valid), 32'h1);
    check("same-edge ovr", 32'(overrun), 32'h0);
    idle(2);

    // Overrun: second good word dropped while dout is full.
    dout_ready = 1'b0;
    exp_q.push_back(4'b1010);
    send_frame(4'b1010, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'b0011, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("overrun dout", 32'(dout), 32'ha);
    check("overrun flag", 32'(overrun), 32'h1);
    check("overrun valid", 32'(dout_valid), 32'h1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("drained valid", 32'(dout_valid), 32'h0);
    check("overrun sticky", 32'(overrun), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("overrun cleared", 32'(overrun), 32'h0);
    dout_ready = 1'b1;
    tick();

`ifdef PARITY_EN
    // Wrong parity is dropped, right parity is delivered.
    exp_perr++;
    send_frame(4'b1010, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("parity bad valid", 32'(dout_valid), 32'h0);
    idle(2);
    exp_q.push_back(4'b1010);
    send_frame(4'b1010, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle(2);
`endif

    idle(3);
    check("words left", 32'(exp_q.size()), 32'h0);
    check("ferr left", 32'(exp_ferr), 32'h0);
    check("perr left", 32'(exp_perr), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
